// File: rtl/br_pkg.sv
// Shared sizes and requester encoding for the register-bank write-port arbiter.
// Pure declarations: no logic, no latency, no flow control.
package br_pkg;
    localparam int NREG = 32;
    localparam int AW   = 5;
    localparam int DW   = 32;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_MEM = 1'b1;
endpackage

// File: rtl/marcador_br.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by issue.
// Updates on the edge, reads are combinational from the registered vector; never stalls.
module marcador_br
    import br_pkg::*;
#(
    parameter bit ZERO_RO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set_vld_i,
    input  logic [AW-1:0] set_reg_i,
    input  logic          clr_vld_i,
    input  logic [AW-1:0] clr_reg_i,
    input  logic [AW-1:0] rd1_reg_i,
    input  logic [AW-1:0] rd2_reg_i,
    output logic          rd1_ocup_o,
    output logic          rd2_ocup_o
);

    logic [NREG-1:0] pend_q;
    logic [NREG-1:0] pend_d;

    // Set is applied after clear: a fresh reservation is a later producer.
    always_comb begin
        pend_d = pend_q;
        if (clr_vld_i) pend_d[clr_reg_i] = 1'b0;
        if (set_vld_i) pend_d[set_reg_i] = 1'b1;
        if (ZERO_RO)   pend_d[0]         = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) pend_q <= '0;
        else     pend_q <= pend_d;
    end

    assign rd1_ocup_o = pend_q[rd1_reg_i];
    assign rd2_ocup_o = pend_q[rd2_reg_i];

endmodule

// File: rtl/br_arbitro_escritura.sv
// Round-robin arbiter (ALU vs memory load) for the bank's single write port, plus hazard scoreboard.
// Grant in cycle T drives WE/DE/DATO in T+1; loser sees rdy low and holds its request.
module br_arbitro_escritura
    import br_pkg::*;
#(
    parameter bit ZERO_RO = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          val_a,
    input  logic [AW-1:0] de_a,
    input  logic [DW-1:0] dato_a,
    output logic          rdy_a,
    input  logic          val_m,
    input  logic [AW-1:0] de_m,
    input  logic [DW-1:0] dato_m,
    output logic          rdy_m,
    input  logic          res_val,
    input  logic [AW-1:0] res_reg,
    input  logic [AW-1:0] DL1,
    input  logic [AW-1:0] DL2,
    output logic          ocup1,
    output logic          ocup2,
    output logic          WE,
    output logic [AW-1:0] DE,
    output logic [DW-1:0] DATO
);

    logic          ult_q, ult_d;
    logic          we_q, we_d;
    logic [AW-1:0] de_q, de_d;
    logic [DW-1:0] dato_q, dato_d;

    logic          gnt_a, gnt_m, gnt;
    logic [AW-1:0] de_gnt;
    logic [DW-1:0] dato_gnt;

    assign gnt_a = !rst && val_a && (!val_m || (ult_q == REQ_MEM));
    assign gnt_m = !rst && val_m && (!val_a || (ult_q == REQ_ALU));
    assign gnt   = gnt_a || gnt_m;

    assign de_gnt   = gnt_a ? de_a   : de_m;
    assign dato_gnt = gnt_a ? dato_a : dato_m;

    always_comb begin
        ult_d  = ult_q;
        we_d   = 1'b0;
        de_d   = de_q;
        dato_d = dato_q;
        if (gnt) begin
            ult_d  = gnt_a ? REQ_ALU : REQ_MEM;
            // Register 0 writes are acknowledged but never reach the bank.
            we_d   = !(ZERO_RO && (de_gnt == '0));
            de_d   = de_gnt;
            dato_d = dato_gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ult_q  <= REQ_MEM;
            we_q   <= 1'b0;
            de_q   <= '0;
            dato_q <= '0;
        end else begin
            ult_q  <= ult_d;
            we_q   <= we_d;
            de_q   <= de_d;
            dato_q <= dato_d;
        end
    end

    marcador_br #(
        .ZERO_RO (ZERO_RO)
    ) u_marcador (
        .clk        (clk),
        .rst        (rst),
        .set_vld_i  (res_val),
        .set_reg_i  (res_reg),
        .clr_vld_i  (gnt),
        .clr_reg_i  (de_gnt),
        .rd1_reg_i  (DL1),
        .rd2_reg_i  (DL2),
        .rd1_ocup_o (ocup1),
        .rd2_ocup_o (ocup2)
    );

    assign rdy_a = gnt_a;
    assign rdy_m = gnt_m;
    assign WE    = we_q;
    assign DE    = de_q;
    assign DATO  = dato_q;

endmodule

// File: doc/br_arbitro_escritura.md
# br_arbitro_escritura

Write-port arbiter and scoreboard for the 32×32 register bank. It shares the bank's single write port (`WE`/`DE`/`DATO`) between two write-back requesters: the ALU result path and the memory-load path. It also tracks registers with an outstanding write, so decode can stall reads of operands that are not yet valid. It sits between the execute/memory stages and the register bank, and is the only driver of the bank's write port.

## Interface

Parameters:
- `ZERO_RO`, default 1: when 1, writes to register 0 are accepted but never issued, and register 0 is never marked pending.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `val_a`, in, 1: ALU write request valid.
- `de_a`, in, 5: ALU destination register.
- `dato_a`, in, 32: ALU write data.
- `rdy_a`, out, 1: ALU request accepted this cycle.
- `val_m`, in, 1: memory write request valid.
- `de_m`, in, 5: memory destination register.
- `dato_m`, in, 32: memory write data.
- `rdy_m`, out, 1: memory request accepted this cycle.
- `res_val`, in, 1: reserve (mark pending) request from decode.
- `res_reg`, in, 5: register to reserve.
- `DL1`, in, 5: read address, port 1 (same value driven to the bank).
- `DL2`, in, 5: read address, port 2.
- `ocup1`, out, 1: `DL1` has a pending write.
- `ocup2`, out, 1: `DL2` has a pending write.
- `WE`, out, 1: bank write enable, registered.
- `DE`, out, 5: bank write address, registered.
- `DATO`, out, 32: bank write data, registered.

## Operation

- Handshake: a requester holds `val_x` with stable `de_x`/`dato_x` until it sees `rdy_x=1` in the same cycle. The transfer occurs on that edge. `rdy_x` is combinational from `val_*` and the arbitration state.
- Arbitration: round-robin, using a 1-bit state `ult` that records the last grant (0 = ALU, 1 = MEM).
  - Only one requester valid: it is granted.
  - Both valid: the one not equal to `ult` is granted.
  - `ult` updates only on a grant.
  - At most one of `rdy_a`/`rdy_m` is high per cycle.
- Issue: on a grant, `WE`/`DE`/`DATO` load the granted request at the edge. `WE=1` lasts for exactly one cycle unless another grant follows. With no grant, `WE` loads 0, and `DE`/`DATO` hold their values.
- Register 0 with `ZERO_RO=1`: the request still gets `rdy`, `ult` still updates, and `WE` loads 0.
- Scoreboard: 32-bit pending vector `pend`.
  - `res_val` sets `pend[res_reg]`.
  - A grant clears `pend[de_granted]`.
  - Same register set and cleared on the same edge: set wins, because the new reservation is a later producer.
  - A reserve of an already-pending register leaves it pending.
  - `pend[0]` is always 0 when `ZERO_RO=1`.
- Hazard outputs: `ocup1 = pend[DL1]`, `ocup2 = pend[DL2]`, combinational from registered `pend`.

## Timing

- Reset values:
  - `WE=0`, `DE=0`, `DATO=0`.
  - `pend=0`, so `ocup1=ocup2=0`.
  - `ult=1`, so the ALU wins the first tie.
  - `rdy_a`/`rdy_m` follow from inputs; with `val_*=0` both are 0.
- Latency: request granted in cycle T, so `WE=1` with that data during cycle T+1. The bank writes combinationally, so reads in T+1 see the new value.
- Scoreboard clear is visible in cycle T+1, so `ocup` drops in the same cycle the data is present.
- Throughput: one write per cycle. With both requesters continuously valid, grants alternate A, M, A, M…
- `rst` asserted mid-operation:
  - In-flight grants are dropped and pending bits are lost.
  - `WE` goes to 0 on the next edge.
  - `rdy_*` are forced to 0 while `rst=1`.

## Structure

- Shared package `br_pkg`:
  - `NREG=32`, `AW=5`, `DW=32`.
  - Requester encoding constants `REQ_ALU=0`, `REQ_MEM=1`.
- One sub-module, `marcador_br`: the pending vector with set/clear ports and two read ports. The arbiter and the write-port register stay in the top module.

## Test plan

- Reset with `val_a=val_m=1`, `de_a=3`, `de_m=4`: first cycle `rdy_a=1`. Next cycle `WE=1`, `DE=3`, and `rdy_m=1`. The cycle after, `DE=4`.
- Continuous dual requests for 6 cycles: grants strictly alternate ALU/MEM, and `WE` stays high every cycle after the first.
- `res_val` on reg 7, then an ALU write to 7 with `dato_a=32'hDEADBEEF` held 2 cycles under MEM contention: `ocup1` (with `DL1=7`) stays 1 until the cycle `WE=1`, `DE=7`, `DATO=DEADBEEF`, then reads 0.
- Reserve and grant for reg 9 on the same edge: `pend[9]` stays 1, and `ocup2` (with `DL2=9`) stays 1 after the write.
- ALU write to reg 0 with `ZERO_RO=1`: `rdy_a=1` and `WE` stays 0. A reserve of reg 0 leaves `ocup1=0` with `DL1=0`.
- `rst` pulsed while `WE=1` and `pend` is nonzero: the next cycle shows `WE=0`, all `ocup=0`, and the next tie is granted to the ALU.
